// File: rtl/hood_pkg.sv
// hood_pkg: shared page encodings, seven-segment glyphs and scan geometry
// for the hood display block.
package hood_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        PAGE_CLOCK = 2'd0,
        PAGE_WORK  = 2'd1,
        PAGE_GEST  = 2'd2
    } page_e;

    // Segment bits: [0]=a .. [6]=g, [7]=dp
    localparam logic [7:0] GLYPH_0     = 8'h3F;
    localparam logic [7:0] GLYPH_1     = 8'h06;
    localparam logic [7:0] GLYPH_2     = 8'h5B;
    localparam logic [7:0] GLYPH_3     = 8'h4F;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'h6D;
    localparam logic [7:0] GLYPH_6     = 8'h7D;
    localparam logic [7:0] GLYPH_7     = 8'h07;
    localparam logic [7:0] GLYPH_8     = 8'h7F;
    localparam logic [7:0] GLYPH_9     = 8'h6F;
    localparam logic [7:0] GLYPH_A     = 8'h77;
    localparam logic [7:0] GLYPH_B     = 8'h7C;
    localparam logic [7:0] GLYPH_C     = 8'h39;
    localparam logic [7:0] GLYPH_D     = 8'h5E;
    localparam logic [7:0] GLYPH_E     = 8'h79;
    localparam logic [7:0] GLYPH_F     = 8'h71;
    localparam logic [7:0] GLYPH_DASH  = 8'h40;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_L     = 8'h38;
    localparam logic [7:0] SEG_DP      = 8'h80;

    // Values latched once per frame so a frame never mixes old and new data
    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [5:0] work_h;
        logic [5:0] work_m;
        logic [5:0] hand;
        logic [3:0] lvl;
        page_e      page;
    } shadow_t;

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// bin6_to_bcd: combinational 6-bit binary to two BCD digits (0..63),
// no clamping of values above 59.
module bin6_to_bcd (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    assign tens = 4'(bin / 6'd10);
    assign ones = 4'(bin % 6'd10);

endmodule

// File: rtl/hood_display.sv
// hood_display: page FSM, 8-digit multiplexed scan with per-frame shadowing.
// Optional remind blink enabled by defining HOOD_DISPLAY_BLINK_EN.
module hood_display
    import hood_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned DIGIT_HZ    = 1000,
    parameter int unsigned BLINK_HZ    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       btn_page,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_second,
    input  logic [5:0] work_hours,
    input  logic [5:0] work_minutes,
    input  logic [5:0] hand_time,
    input  logic [3:0] state_smoke_lvl,
    input  logic       remind,
    output logic [7:0] seg_en,
    output logic [7:0] seg_out,
    output logic [1:0] page
);

    localparam int unsigned DIV = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

    logic [2:0]       sync_q, sync_d;
    logic             page_evt;
    page_e            page_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             wrap;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [7:0]       seg_en_q, seg_en_d;
    logic [7:0]       seg_out_q, seg_out_d;
    shadow_t          sh_q, sh_d;
    logic [7:0]       glyph;

    logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
    logic [3:0] wh_t, wh_o, wm_t, wm_o, ht_t, ht_o;

    bin6_to_bcd u_bcd_hour (.bin(sh_q.hour),   .tens(h_t),  .ones(h_o));
    bin6_to_bcd u_bcd_min  (.bin(sh_q.min),    .tens(m_t),  .ones(m_o));
    bin6_to_bcd u_bcd_sec  (.bin(sh_q.sec),    .tens(s_t),  .ones(s_o));
    bin6_to_bcd u_bcd_wh   (.bin(sh_q.work_h), .tens(wh_t), .ones(wh_o));
    bin6_to_bcd u_bcd_wm   (.bin(sh_q.work_m), .tens(wm_t), .ones(wm_o));
    bin6_to_bcd u_bcd_hand (.bin(sh_q.hand),   .tens(ht_t), .ones(ht_o));

    assign sync_d   = {sync_q[1:0], btn_page};
    assign page_evt = sync_q[1] & ~sync_q[2];
    assign wrap     = (presc_q == PRESC_LAST);

    // Page FSM: advances on each button edge, pinned to CLOCK when powered off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q <= PAGE_CLOCK;
        end else if (!power_on) begin
            page_q <= PAGE_CLOCK;
        end else if (page_evt) begin
            unique case (page_q)
                PAGE_CLOCK: page_q <= PAGE_WORK;
                PAGE_WORK:  page_q <= PAGE_GEST;
                default:    page_q <= PAGE_CLOCK;
            endcase
        end
    end

    // Glyph for the digit about to be shown, taken from the frame shadow
    always_comb begin
        glyph = GLYPH_BLANK;
        unique case (sh_q.page)
            PAGE_CLOCK: begin
                case (dig_q)
                    3'd0:    glyph = hex_glyph(h_t);
                    3'd1:    glyph = hex_glyph(h_o);
                    3'd2:    glyph = GLYPH_DASH;
                    3'd3:    glyph = hex_glyph(m_t);
                    3'd4:    glyph = hex_glyph(m_o);
                    3'd5:    glyph = GLYPH_DASH;
                    3'd6:    glyph = hex_glyph(s_t);
                    default: glyph = hex_glyph(s_o);
                endcase
            end
            PAGE_WORK: begin
                case (dig_q)
                    3'd0:    glyph = hex_glyph(wh_t);
                    3'd1:    glyph = hex_glyph(wh_o);
                    3'd2:    glyph = GLYPH_DASH;
                    3'd3:    glyph = hex_glyph(wm_t);
                    3'd4:    glyph = hex_glyph(wm_o);
                    default: glyph = GLYPH_BLANK;
                endcase
            end
            PAGE_GEST: begin
                case (dig_q)
                    3'd0:    glyph = GLYPH_L;
                    3'd1:    glyph = hex_glyph(sh_q.lvl);
                    3'd6:    glyph = hex_glyph(ht_t);
                    3'd7:    glyph = hex_glyph(ht_o);
                    default: glyph = GLYPH_BLANK;
                endcase
            end
            default: glyph = GLYPH_BLANK;
        endcase
    end

`ifdef HOOD_DISPLAY_BLINK_EN
    localparam int unsigned BDIV = CLK_FREQ_HZ / BLINK_HZ;
    localparam int unsigned BW   = (BDIV > 1) ? $clog2(BDIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BDIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Free-running blink timer; phase flips once per blink interval
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Blink state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`else
    logic unused_blink_hz;
    assign unused_blink_hz = (BLINK_HZ != 0);
`endif

    // Scan timing, digit output registers and frame-boundary shadow capture
    always_comb begin
        presc_d   = wrap ? '0 : presc_q + 1'b1;
        dig_d     = dig_q;
        seg_en_d  = seg_en_q;
        seg_out_d = seg_out_q;
        sh_d      = sh_q;
        if (wrap) begin
            dig_d     = dig_q + 1'b1;
            seg_en_d  = 8'b1 << dig_q;
            seg_out_d = glyph;
`ifdef HOOD_DISPLAY_BLINK_EN
            if (remind && blink_q) begin
                seg_out_d = GLYPH_BLANK;
            end
`else
            if (remind && dig_q == LAST_DIGIT) begin
                seg_out_d = glyph | SEG_DP;
            end
`endif
            if (dig_q == LAST_DIGIT) begin
                sh_d.hour   = cur_hour;
                sh_d.min    = cur_min;
                sh_d.sec    = cur_second;
                sh_d.work_h = work_hours;
                sh_d.work_m = work_minutes;
                sh_d.hand   = hand_time;
                sh_d.lvl    = state_smoke_lvl;
                sh_d.page   = page_q;
            end
        end
        if (!power_on) begin
            seg_en_d = '0;
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            presc_q   <= '0;
            dig_q     <= '0;
            seg_en_q  <= '0;
            seg_out_q <= '0;
            sh_q      <= '0;
        end else begin
            sync_q    <= sync_d;
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
            sh_q      <= sh_d;
        end
    end

    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;
    assign page    = page_q;

endmodule

// File: tb/tb_hood_display.sv
// tb_hood_display: directed vector bench for hood_display
// (10 clocks per digit, 80 clocks per frame).
module tb_hood_display;

    logic       clk;
    logic       reset;
    logic       power_on;
    logic       btn_page;
    logic [5:0] cur_hour, cur_min, cur_second;
    logic [5:0] work_hours, work_minutes, hand_time;
    logic [3:0] state_smoke_lvl;
    logic       remind;
    logic [7:0] seg_en;
    logic [7:0] seg_out;
    logic [1:0] page;

    int passed;
    int total;
    int cyc;

    hood_display #(
        .CLK_FREQ_HZ(1000),
        .DIGIT_HZ   (100),
        .BLINK_HZ   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .power_on       (power_on),
        .btn_page       (btn_page),
        .cur_hour       (cur_hour),
        .cur_min        (cur_min),
        .cur_second     (cur_second),
        .work_hours     (work_hours),
        .work_minutes   (work_minutes),
        .hand_time      (hand_time),
        .state_smoke_lvl(state_smoke_lvl),
        .remind         (remind),
        .seg_en         (seg_en),
        .seg_out        (seg_out),
        .page           (page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [1:0] pg;
        logic [5:0] h, m, s, wh, wm, ht;
        logic [3:0] lvl;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_en(input logic [7:0] v);
        int n;
        n = 0;
        while (seg_en == v && n < 400) begin
            @(posedge clk); #1; n++;
        end
        while (seg_en != v && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 400) begin
            total++;
            $display("FAIL wait_en timeout: seg_en %0h expected %0h", seg_en, v);
        end
    endtask

    task automatic press(input int w);
        btn_page = 1'b1;
        repeat (w) @(posedge clk);
        #1 btn_page = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic goto_page(input logic [1:0] tgt);
        int k;
        k = 0;
        while (page != tgt && k < 4) begin
            press(5);
            k++;
        end
        chk("goto_page", page, tgt);
    endtask

    // Checks digits start..7 of the current frame, plus the digit period
    task automatic check_frame(input string nm, input logic [63:0] exp,
                               input int start);
        int last;
        last = cyc;
        for (int d = start; d < 8; d++) begin
            wait_en(8'(1 << d));
            chk({nm, "_digit"}, seg_out, exp[63 - 8 * d -: 8]);
            if (d > start) chk({nm, "_period"}, cyc - last, 10);
            last = cyc;
        end
    endtask

    task automatic count_first_wrap(input string nm);
        int n;
        n = 0;
        while (seg_en == 8'h00 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_wrap_cycles"}, n, 10);
        chk({nm, "_first_en"}, seg_en, 8'h01);
    endtask

    initial begin
        passed = 0;
        total  = 0;

        vecs[0] = '{"clk_123456", 2'd0, 12, 34, 56, 7, 45, 63, 4'hA,
                    64'h06_5B_40_4F_66_40_6D_7D};
        vecs[1] = '{"clk_unclamped", 2'd0, 63, 60, 9, 7, 45, 63, 4'hA,
                    64'h7D_4F_40_7D_3F_40_3F_6F};
        vecs[2] = '{"work_0745", 2'd1, 0, 0, 0, 7, 45, 0, 4'h0,
                    64'h3F_07_40_66_6D_00_00_00};
        vecs[3] = '{"work_6000", 2'd1, 0, 0, 0, 60, 0, 0, 4'h0,
                    64'h7D_3F_40_3F_3F_00_00_00};
        vecs[4] = '{"gest_A63", 2'd2, 0, 0, 0, 0, 0, 63, 4'hA,
                    64'h38_77_00_00_00_00_7D_4F};
        vecs[5] = '{"gest_F05", 2'd2, 0, 0, 0, 0, 0, 5, 4'hF,
                    64'h38_71_00_00_00_00_3F_6D};
        vecs[6] = '{"gest_010", 2'd2, 0, 0, 0, 0, 0, 10, 4'h0,
                    64'h38_3F_00_00_00_00_06_3F};

        power_on        = 1'b1;
        btn_page        = 1'b0;
        remind          = 1'b0;
        cur_hour        = 6'd12;
        cur_min         = 6'd34;
        cur_second      = 6'd56;
        work_hours      = 6'd7;
        work_minutes    = 6'd45;
        hand_time       = 6'd63;
        state_smoke_lvl = 4'hA;

        // Reset state
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg_en", seg_en, 8'h00);
        chk("rst_seg_out", seg_out, 8'h00);
        chk("rst_page", page, 2'd0);
        reset = 1'b1;

        // First wrap after release shows digit 0 from zeroed shadows
        count_first_wrap("boot");
        chk("boot_d0_zero", seg_out, 8'h3F);
        check_frame("boot_zero", 64'h3F_3F_40_3F_3F_40_3F_3F, 1);

        // Page advance: 5-clock pulses, then one long pulse
        chk("pg_start", page, 2'd0);
        press(5); chk("pg_adv1", page, 2'd1);
        press(5); chk("pg_adv2", page, 2'd2);
        press(5); chk("pg_adv3", page, 2'd0);
        press(20); chk("pg_long", page, 2'd1);

        // Table-driven frame contents
        for (int i = 0; i < 7; i++) begin
            cur_hour        = vecs[i].h;
            cur_min         = vecs[i].m;
            cur_second      = vecs[i].s;
            work_hours      = vecs[i].wh;
            work_minutes    = vecs[i].wm;
            hand_time       = vecs[i].ht;
            state_smoke_lvl = vecs[i].lvl;
            goto_page(vecs[i].pg);
            wait_en(8'h80);
            check_frame(vecs[i].name, vecs[i].exp, 0);
        end

        // Mid-frame update is held until the next frame
        goto_page(2'd0);
        cur_hour   = 6'd12;
        cur_min    = 6'd34;
        cur_second = 6'd56;
        wait_en(8'h80);
        wait_en(8'h08);
        cur_second = 6'd57;
        wait_en(8'h40); chk("hold_d6", seg_out, 8'h6D);
        wait_en(8'h80); chk("hold_d7_old", seg_out, 8'h7D);
        wait_en(8'h01); chk("hold_d0", seg_out, 8'h06);
        wait_en(8'h80); chk("hold_d7_new", seg_out, 8'h07);

`ifndef HOOD_DISPLAY_BLINK_EN
        // Remind lights dp on the last digit only
        remind = 1'b1;
        wait_en(8'h40); chk("remind_d6", seg_out, 8'h6D);
        wait_en(8'h80); chk("remind_d7", seg_out, 8'h87);
        remind = 1'b0;
        wait_en(8'h80); chk("remind_off_d7", seg_out, 8'h07);
`endif

        // Power off on WORK page
        goto_page(2'd1);
        power_on = 1'b0;
        @(posedge clk); #1;
        chk("off_seg_en", seg_en, 8'h00);
        chk("off_page", page, 2'd0);
        press(5);
        chk("off_btn_ignored", page, 2'd0);
        begin
            int lit;
            lit = 0;
            repeat (100) begin
                @(posedge clk); #1;
                if (seg_en != 8'h00) lit++;
            end
            chk("off_dark", lit, 0);
        end
        power_on = 1'b1;

        // Asynchronous reset mid-frame
        goto_page(2'd2);
        wait_en(8'h08);
        #3 reset = 1'b0;
        #1;
        chk("async_seg_en", seg_en, 8'h00);
        chk("async_seg_out", seg_out, 8'h00);
        chk("async_page", page, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_en", seg_en, 8'h00);
        reset = 1'b1;
        count_first_wrap("rerun");
        chk("rerun_d0_zero", seg_out, 8'h3F);
        check_frame("rerun_zero", 64'h3F_3F_40_3F_3F_40_3F_3F, 1);

`ifdef HOOD_DISPLAY_BLINK_EN
        // Blink: with remind set, both blanked and lit digits appear
        begin
            int blank_n, lit_n;
            blank_n = 0;
            lit_n   = 0;
            remind  = 1'b1;
            wait_en(8'h01);
            repeat (1200) begin
                @(posedge clk); #1;
                if (seg_en != 8'h00 && seg_out == 8'h00) blank_n++;
                if (seg_out != 8'h00) lit_n++;
            end
            chk("blink_has_blank", int'(blank_n > 0), 1);
            chk("blink_has_lit", int'(lit_n > 0), 1);
            remind  = 1'b0;
            blank_n = 0;
            wait_en(8'h02);
            repeat (600) begin
                @(posedge clk); #1;
                if (seg_out == 8'h00) blank_n++;
            end
            chk("blink_off_steady", blank_n, 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
